// File: rtl/vjtag_mem_bridge_if.sv
// Memory-side bus of the virtual-JTAG bridge: address, write data/strobe
// and read data from a synchronous RAM (one tck of read latency).
interface vjtag_mem_bridge_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
);
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_addr,
        output mem_wdata,
        output mem_we,
        input  mem_rdata
    );

    modport slave (
        input  mem_addr,
        input  mem_wdata,
        input  mem_we,
        output mem_rdata
    );
endinterface

// File: rtl/vjtag_mem_bridge.sv
// Virtual-JTAG to memory bridge: ADDR/WDATA/RDATA data registers with an
// auto-incrementing address, sticky length-error flag reported through IR capture.
module vjtag_mem_bridge #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
) (
    input  logic                tck,
    input  logic                reset,
    input  logic                tdi,
    output logic                tdo,
    input  logic [1:0]          ir_in,
    output logic [1:0]          ir_out,
    input  logic                virtual_state_cdr,
    input  logic                virtual_state_sdr,
    input  logic                virtual_state_udr,
    input  logic                virtual_state_cir,
    input  logic                virtual_state_uir,
    input  logic                proc_done,
    vjtag_mem_bridge_if.master  mem
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } state_t;

    localparam logic [1:0] IR_BYPASS = 2'b00;
    localparam logic [1:0] IR_ADDR   = 2'b01;
    localparam logic [1:0] IR_WDATA  = 2'b10;
    localparam logic [1:0] IR_RDATA  = 2'b11;

    localparam logic [5:0] ADDR_LEN = 6'(ADDR_W);
    localparam logic [5:0] DATA_LEN = 6'(DATA_W);
    localparam logic [4:0] CNT_MAX  = 5'd31;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] shift_q, shift_d;
    logic [4:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              mem_we_q, mem_we_d;
    logic              err_q, err_d;
    logic [1:0]        ir_out_q, ir_out_d;
    logic              dr_valid;

    // BYPASS never errors; the other registers need exactly their field length.
    always_comb begin
        case (ir_in)
            IR_ADDR:            dr_valid = ({1'b0, cnt_q} == ADDR_LEN);
            IR_WDATA, IR_RDATA: dr_valid = ({1'b0, cnt_q} == DATA_LEN);
            default:            dr_valid = 1'b1;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        cnt_d       = cnt_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_we_d    = 1'b0;
        err_d       = err_q;
        ir_out_d    = ir_out_q;

        if (virtual_state_cir) begin
            ir_out_d = {err_q, proc_done};
        end
        if (virtual_state_uir && (ir_in == IR_BYPASS)) begin
            err_d = 1'b0;
        end

        // The write strobe is high for the whole COMMIT cycle; the address moves on after it.
        if (state_q == COMMIT) begin
            mem_addr_d = mem_addr_q + ADDR_W'(1);
            state_d    = IDLE;
        end

        if (virtual_state_cdr) begin
            case (ir_in)
                IR_ADDR: shift_d = mem_addr_q;
                IR_RDATA: begin
                    shift_d               = '0;
                    shift_d[DATA_W-1:0]   = mem.mem_rdata;
                end
                default: shift_d = '0;
            endcase
            cnt_d   = '0;
            state_d = SHIFT;
        end else if (virtual_state_sdr) begin
            case (ir_in)
                IR_ADDR: shift_d = {tdi, shift_q[ADDR_W-1:1]};
                IR_WDATA, IR_RDATA: begin
                    for (int i = 0; i < DATA_W - 1; i++) begin
                        shift_d[i] = shift_q[i+1];
                    end
                    shift_d[DATA_W-1] = tdi;
                end
                default: shift_d[0] = tdi;
            endcase
            cnt_d = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + 5'd1;
        end else if (virtual_state_udr && (state_q == SHIFT)) begin
            state_d = IDLE;
            if (!dr_valid) begin
                err_d = 1'b1;
            end else begin
                case (ir_in)
                    IR_ADDR: mem_addr_d = shift_q;
                    IR_WDATA: begin
                        mem_wdata_d = shift_q[DATA_W-1:0];
                        mem_we_d    = 1'b1;
                        state_d     = COMMIT;
                    end
                    IR_RDATA: mem_addr_d = mem_addr_q + ADDR_W'(1);
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge tck) begin
        if (reset) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            cnt_q       <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            err_q       <= 1'b0;
            ir_out_q    <= 2'b00;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            cnt_q       <= cnt_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
            err_q       <= err_d;
            ir_out_q    <= ir_out_d;
        end
    end

    // Gating with reset lets a reset that lands in COMMIT cancel the pending write.
    assign mem.mem_we    = mem_we_q & ~reset;
    assign mem.mem_addr  = mem_addr_q;
    assign mem.mem_wdata = mem_wdata_q;
    assign tdo           = shift_q[0];
    assign ir_out        = ir_out_q;

endmodule

// File: tb/tb_vjtag_mem_bridge.sv
// Randomized bench for vjtag_mem_bridge against a shift-stream / memory reference model.
module tb_vjtag_mem_bridge;
    localparam int ADDR_W = 16;
    localparam int DATA_W = 8;
    localparam logic [1:0] IR_BYP = 2'b00;
    localparam logic [1:0] IR_ADR = 2'b01;
    localparam logic [1:0] IR_WR  = 2'b10;
    localparam logic [1:0] IR_RD  = 2'b11;

    logic       tck = 1'b0;
    logic       reset, tdi, tdo, proc_done;
    logic [1:0] ir_in, ir_out;
    logic       cdr, sdr, udr, cir, uir;

    int n_vec = 0;
    int n_err = 0;

    vjtag_mem_bridge_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) mem_if ();

    vjtag_mem_bridge #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .tck(tck), .reset(reset), .tdi(tdi), .tdo(tdo),
        .ir_in(ir_in), .ir_out(ir_out),
        .virtual_state_cdr(cdr), .virtual_state_sdr(sdr), .virtual_state_udr(udr),
        .virtual_state_cir(cir), .virtual_state_uir(uir),
        .proc_done(proc_done), .mem(mem_if)
    );

    always #5 tck = ~tck;

    // Environment RAM with one cycle of read latency.
    logic [DATA_W-1:0] ram [0:(1<<ADDR_W)-1] = '{default: 8'h00};
    always @(posedge tck) begin
        if (mem_if.mem_we) ram[mem_if.mem_addr] <= mem_if.mem_wdata;
        mem_if.mem_rdata <= ram[mem_if.mem_addr];
    end

    // Reference model state.
    logic [DATA_W-1:0] m_mem [0:(1<<ADDR_W)-1] = '{default: 8'h00};
    logic [ADDR_W-1:0] m_addr = '0;
    logic              m_err  = 1'b0;

    task automatic tick();
        @(posedge tck);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic shift_udr(input int nbits, input logic [31:0] data, output logic [31:0] seen);
        seen = '0;
        for (int i = 0; i < nbits; i++) begin
            seen[i] = tdo;
            sdr = 1'b1;
            tdi = data[i];
            tick();
        end
        sdr = 1'b0;
        tdi = 1'b0;
        udr = 1'b1;
        tick();
        udr = 1'b0;
    endtask

    task automatic dr_op(input logic [1:0] ir, input int nbits, input logic [31:0] data,
                         output logic [31:0] seen);
        ir_in = ir;
        cdr   = 1'b1;
        tick();
        cdr   = 1'b0;
        shift_udr(nbits, data, seen);
    endtask

    // A DR behaves as an L-bit FIFO: tdo first drains the captured value, then earlier tdi bits.
    task automatic run_op(input string tag, input logic [1:0] ir, input int nbits,
                          input logic [31:0] data, output logic [31:0] seen);
        int          len;
        logic [63:0] pre;
        logic [63:0] stream;
        logic [31:0] exp_tdo;
        bit          valid;
        bit          wr;
        case (ir)
            IR_ADR:  begin len = ADDR_W; pre = 64'(m_addr);        end
            IR_WR:   begin len = DATA_W; pre = 64'd0;              end
            IR_RD:   begin len = DATA_W; pre = 64'(m_mem[m_addr]); end
            default: begin len = 1;      pre = 64'd0;              end
        endcase
        stream  = pre | (64'(data) << len);
        exp_tdo = '0;
        for (int i = 0; i < nbits; i++) exp_tdo[i] = stream[i];
        valid = (ir == IR_BYP) || (nbits == len);
        wr    = valid && (ir == IR_WR);

        dr_op(ir, nbits, data, seen);
        chk({tag, ".tdo"}, seen, exp_tdo);
        chk({tag, ".we"}, 32'(mem_if.mem_we), 32'(wr));
        if (wr) begin
            chk({tag, ".wdata"}, 32'(mem_if.mem_wdata), 32'(data[7:0]));
            chk({tag, ".waddr"}, 32'(mem_if.mem_addr), 32'(m_addr));
            m_mem[m_addr] = data[7:0];
        end
        if (!valid)             m_err  = 1'b1;
        else if (ir == IR_ADR)  m_addr = data[15:0];
        else if (ir != IR_BYP)  m_addr = m_addr + 16'd1;
        tick();
        chk({tag, ".we_off"}, 32'(mem_if.mem_we), 32'd0);
        chk({tag, ".addr"}, 32'(mem_if.mem_addr), 32'(m_addr));
        tick();
    endtask

    task automatic do_cir(input string tag);
        cir = 1'b1;
        tick();
        cir = 1'b0;
        chk({tag, ".ir_out"}, 32'(ir_out), 32'({m_err, proc_done}));
    endtask

    task automatic do_uir(input logic [1:0] ir);
        ir_in = ir;
        uir   = 1'b1;
        tick();
        uir   = 1'b0;
        if (ir == IR_BYP) m_err = 1'b0;
    endtask

    initial begin
        logic [31:0] seen;
        logic [1:0]  rir;
        int          rlen, rbits;
        logic [31:0] rdata;
        logic [15:0] waddr;

        reset = 1'b1; tdi = 1'b0; ir_in = 2'b00; proc_done = 1'b0;
        cdr = 1'b0; sdr = 1'b0; udr = 1'b0; cir = 1'b0; uir = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        chk("rst.tdo", 32'(tdo), 32'd0);
        chk("rst.ir_out", 32'(ir_out), 32'd0);
        chk("rst.addr", 32'(mem_if.mem_addr), 32'd0);
        chk("rst.we", 32'(mem_if.mem_we), 32'd0);
        chk("rst.wdata", 32'(mem_if.mem_wdata), 32'd0);

        // Directed scenarios.
        run_op("addr1234", IR_ADR, 16, 32'h1234, seen);
        chk("addr1234.prev", seen, 32'h0000);
        chk("addr1234.val", 32'(mem_if.mem_addr), 32'h1234);
        run_op("wrA5", IR_WR, 8, 32'hA5, seen);
        chk("wrA5.next", 32'(mem_if.mem_addr), 32'h1235);

        run_op("addr10", IR_ADR, 16, 32'h0010, seen);
        run_op("wr3C", IR_WR, 8, 32'h3C, seen);
        run_op("addr10b", IR_ADR, 16, 32'h0010, seen);
        run_op("rd3C", IR_RD, 8, 32'h0, seen);
        chk("rd3C.bits", seen, 32'h3C);
        chk("rd3C.next", 32'(mem_if.mem_addr), 32'h0011);

        run_op("wr7bit", IR_WR, 7, 32'h55, seen);
        chk("wr7bit.addr", 32'(mem_if.mem_addr), 32'h0011);
        do_cir("err_set");
        chk("err_set.const", 32'(ir_out), 32'h2);
        do_uir(IR_ADR);
        do_cir("err_keep");
        do_uir(IR_BYP);
        do_cir("err_clr");
        chk("err_clr.const", 32'(ir_out), 32'h0);
        proc_done = 1'b1;
        do_cir("done");

        run_op("addrFFFF", IR_ADR, 16, 32'hFFFF, seen);
        run_op("wrwrap", IR_WR, 8, 32'h01, seen);
        chk("wrwrap.addr", 32'(mem_if.mem_addr), 32'h0000);
        chk("wrwrap.ram", 32'(ram[16'hFFFF]), 32'h01);

        // Capture arriving during COMMIT: the first write completes, a second one follows.
        run_op("addr200", IR_ADR, 16, 32'h0200, seen);
        dr_op(IR_WR, 8, 32'h11, seen);
        chk("b2b.we1", 32'(mem_if.mem_we), 32'd1);
        chk("b2b.addr1", 32'(mem_if.mem_addr), 32'h0200);
        ir_in = IR_WR;
        cdr = 1'b1;
        tick();
        cdr = 1'b0;
        m_mem[m_addr] = 8'h11;
        m_addr = m_addr + 16'd1;
        chk("b2b.addr_inc", 32'(mem_if.mem_addr), 32'(m_addr));
        chk("b2b.we_off", 32'(mem_if.mem_we), 32'd0);
        shift_udr(8, 32'h22, seen);
        chk("b2b.we2", 32'(mem_if.mem_we), 32'd1);
        chk("b2b.wdata2", 32'(mem_if.mem_wdata), 32'h22);
        chk("b2b.addr2", 32'(mem_if.mem_addr), 32'(m_addr));
        m_mem[m_addr] = 8'h22;
        m_addr = m_addr + 16'd1;
        tick();
        chk("b2b.end", 32'(mem_if.mem_addr), 32'(m_addr));
        chk("b2b.ram1", 32'(ram[16'h0200]), 32'h11);
        tick();

        // Randomized mix of valid and mis-sized DR operations.
        for (int k = 0; k < 60; k++) begin
            rir = 2'($urandom_range(0, 3));
            rlen = (rir == IR_ADR) ? ADDR_W : (rir == IR_BYP) ? 1 : DATA_W;
            rbits = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 20)) : rlen;
            rdata = $urandom;
            proc_done = 1'($urandom_range(0, 1));
            run_op($sformatf("rnd%0d", k), rir, rbits, rdata, seen);
            if (k % 5 == 4) do_cir($sformatf("rnd%0d", k));
            if (k % 9 == 8) do_uir(2'($urandom_range(0, 1)));
        end

        // Reset landing in COMMIT cancels the write and restores every output.
        run_op("pre_rst_addr", IR_ADR, 16, 32'h0ABC, seen);
        run_op("pre_rst_err", IR_RD, 3, 32'h0, seen);
        proc_done = 1'b0;
        do_cir("pre_rst");
        waddr = m_addr;
        dr_op(IR_WR, 8, 32'h5A, seen);
        chk("rst_commit.we_pre", 32'(mem_if.mem_we), 32'd1);
        reset = 1'b1;
        #1;
        chk("rst_commit.we", 32'(mem_if.mem_we), 32'd0);
        tick();
        reset = 1'b0;
        m_addr = '0;
        m_err  = 1'b0;
        chk("rst_commit.addr", 32'(mem_if.mem_addr), 32'd0);
        chk("rst_commit.we_after", 32'(mem_if.mem_we), 32'd0);
        chk("rst_commit.wdata", 32'(mem_if.mem_wdata), 32'd0);
        chk("rst_commit.tdo", 32'(tdo), 32'd0);
        chk("rst_commit.ir_out", 32'(ir_out), 32'd0);
        tick();
        chk("rst_commit.ram", 32'(ram[waddr]), 32'(m_mem[waddr]));
        run_op("post_rst", IR_RD, 8, 32'h0, seen);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/vjtag_mem_bridge.md
VJTAG_MEM_BRIDGE -- requirements
Module: vjtag_mem_bridge

Interface
REQ-001 Parameter ADDR_W, default 16, memory address width and address-DR length.
REQ-002 Parameter DATA_W, default 8, memory data width and data-DR length.
REQ-003 tck  input  1  sole clock, driven from the virtual JTAG tck output; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 tdi  input  1  serial data in from the virtual JTAG.
REQ-006 tdo  output  1  serial data out to the virtual JTAG.
REQ-007 ir_in  input  2  current virtual IR value.
REQ-008 ir_out  output  2  IR capture value returned to the virtual JTAG.
REQ-009 virtual_state_cdr, virtual_state_sdr, virtual_state_udr, virtual_state_cir, virtual_state_uir  input  1 each  one-cycle/level TAP state flags.
REQ-010 mem_addr  output  ADDR_W  memory address.
REQ-011 mem_wdata  output  DATA_W  memory write data.
REQ-012 mem_we  output  1  one-cycle write strobe.
REQ-013 mem_rdata  input  DATA_W  read data, valid one tck after mem_addr changes (synchronous RAM).
REQ-014 proc_done  input  1  downscaler completion flag, reported in ir_out.

Function
REQ-015 IR decode SHALL be: 2'b00 BYPASS, 2'b01 ADDR, 2'b10 WDATA, 2'b11 RDATA.
REQ-016 Internal DR shift register SHALL be ADDR_W bits; BYPASS uses bit 0 only, WDATA/RDATA use bits [DATA_W-1:0], ADDR uses all bits.
REQ-017 tdo SHALL equal shift register bit 0 (registered, no combinational path from tdi).
REQ-018 Flag priority when several are high SHALL be cdr > sdr > udr; cir/uir are independent of DR flags.
REQ-019 On cdr: ADDR loads mem_addr; WDATA loads 0; RDATA loads mem_rdata into [DATA_W-1:0]; BYPASS loads 0; bit counter cleared to 0.
REQ-020 On sdr: active field shifts right LSB-first with tdi entering its MSB (ADDR: bit ADDR_W-1; WDATA/RDATA: bit DATA_W-1; BYPASS: bit 0); bit counter increments, saturating at 31.
REQ-021 FSM states IDLE, SHIFT, COMMIT: IDLE->SHIFT on cdr; SHIFT->IDLE on udr (ADDR, RDATA, BYPASS, or any error); SHIFT->COMMIT on udr for valid WDATA; COMMIT->IDLE unconditionally next cycle.
REQ-022 A DR operation is valid only when counter equals the field length (ADDR_W for ADDR, DATA_W for WDATA/RDATA); BYPASS is always valid.
REQ-023 Valid ADDR udr: mem_addr <= shift register, effective next cycle.
REQ-024 Valid WDATA udr: mem_wdata <= shift[DATA_W-1:0] and mem_we = 1 for exactly the COMMIT cycle with mem_addr unchanged; mem_addr increments at the end of COMMIT.
REQ-025 Valid RDATA udr: mem_addr increments by 1 on the udr edge; no write.
REQ-026 Address increment SHALL wrap modulo 2^ADDR_W (all-ones -> 0).
REQ-027 Invalid ADDR/WDATA/RDATA udr: no address, data or strobe change; sticky err flag set.
REQ-028 udr while in IDLE (no preceding cdr) SHALL be ignored.
REQ-029 ir_out SHALL be registered on cir as {err, proc_done}, and held otherwise.
REQ-030 On uir with ir_in == 2'b00, err SHALL clear; uir with other codes has no effect.
REQ-031 cdr arriving in COMMIT SHALL still complete the write, then enter SHIFT on the following cycle.

Reset
REQ-032 reset SHALL override all flags in the same edge: state IDLE, shift register 0, counter 0, mem_addr 0, mem_wdata 0, mem_we 0, err 0, ir_out 2'b00, tdo 0.
REQ-033 reset asserted during COMMIT SHALL suppress mem_we in that cycle and leave mem_addr at 0.

Verification
REQ-034 ADDR cycle shifting 16 bits 0x1234 LSB-first then udr -> mem_addr = 0x1234; tdo stream during shift = previous address 0x0000.
REQ-035 WDATA 0xA5 with mem_addr 0x1234 -> one-cycle mem_we with mem_wdata 0xA5 at addr 0x1234, then mem_addr 0x1235.
REQ-036 RDATA at 0x0010 with memory holding 0x3C -> tdo shifts 0,0,1,1,1,1,0,0; mem_addr 0x0011 after udr.
REQ-037 WDATA with only 7 bits shifted -> no mem_we, mem_addr unchanged, next cir gives ir_out 2'b10; uir with ir_in 00 then cir -> 2'b00.
REQ-038 mem_addr 0xFFFF, valid WDATA 0x01 -> write at 0xFFFF, mem_addr wraps to 0x0000.
REQ-039 reset during COMMIT -> mem_we 0 that cycle, all outputs at reset values next cycle.
